// File: rtl/alu_pkg.sv
// Shared ALU control encodings, LEGv8 opcodes, sequencer state and class types.
// Imported by the ALU and the multicycle sequencer; no ports.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_AND      = 4'b0000,
    ALU_OR       = 4'b0001,
    ALU_ADD      = 4'b0010,
    ALU_SUB      = 4'b0110,
    ALU_PASS_B   = 4'b0111,
    ALU_NOR      = 4'b1100,
    ALU_LSL_B_00 = 4'b1000,
    ALU_LSL_B_01 = 4'b1001,
    ALU_LSL_B_10 = 4'b1010,
    ALU_LSL_B_11 = 4'b1011
  } alu_ctl_e;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [8:0]  OP_MOVZ_HI = 9'b110100101;
  localparam logic [7:0]  OP_CBZ_HI  = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ_HI = 8'b10110101;
  localparam logic [5:0]  OP_B_HI    = 6'b000101;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_EXEC_MOVZ,
    S_WB_ALU,
    S_ADDR,
    S_MEM_RD,
    S_WB_MEM,
    S_MEM_WR,
    S_BRANCH,
    S_JUMP,
    S_FAULT
  } state_e;

  typedef enum logic [1:0] {
    SRC_B_RM      = 2'd0,
    SRC_B_FOUR    = 2'd1,
    SRC_B_IMM     = 2'd2,
    SRC_B_IMM_SH2 = 2'd3
  } src_b_e;

  typedef enum logic [2:0] {
    CLS_R,
    CLS_LOAD,
    CLS_STORE,
    CLS_MOVZ,
    CLS_BRANCH,
    CLS_JUMP,
    CLS_ILLEGAL
  } op_class_e;

  // neg: branch taken when zero=0 (CBNZ sense)
  typedef struct packed {
    op_class_e cls;
    alu_ctl_e  alu;
    logic      neg;
  } decode_t;

  localparam decode_t DEC_RST = '{cls: CLS_ILLEGAL, alu: ALU_AND, neg: 1'b0};

endpackage

// File: rtl/multicycle_alu_sequencer_if.sv
// Control bundle between the multicycle sequencer (master) and datapath (slave).
// Inputs: start, opcode, zero, mem_ready. Outputs: ALU control, selects, strobes, fault.
interface multicycle_alu_sequencer_if;
  logic        start;
  logic [10:0] opcode;
  logic        zero;
  logic        mem_ready;
  logic [3:0]  ALUControl;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic        pc_write;
  logic        pc_write_cond;
  logic        ir_write;
  logic        mem_read;
  logic        mem_write;
  logic        reg_write;
  logic        mem_to_reg;
  logic        instr_done;
  logic        fault;

  modport master (
    input  start, opcode, zero, mem_ready,
    output ALUControl, alu_src_a, alu_src_b,
    output pc_write, pc_write_cond, ir_write,
    output mem_read, mem_write, reg_write,
    output mem_to_reg, instr_done, fault
  );

  modport slave (
    output start, opcode, zero, mem_ready,
    input  ALUControl, alu_src_a, alu_src_b,
    input  pc_write, pc_write_cond, ir_write,
    input  mem_read, mem_write, reg_write,
    input  mem_to_reg, instr_done, fault
  );
endinterface

// File: rtl/multicycle_alu_sequencer_opcode_classifier.sv
// Combinational opcode -> class / ALUControl lookup. In: opcode[10:0]. Out: dec.
// Macro CBNZ_EN adds CBNZ as an inverted-sense branch; otherwise it is illegal.
module multicycle_alu_sequencer_opcode_classifier
  import alu_pkg::*;
(
  input  logic [10:0] opcode,
  output decode_t     dec
);

  always_comb begin
    dec = DEC_RST;
    unique case (1'b1)
      opcode == OP_ADD:  dec = '{CLS_R, ALU_ADD, 1'b0};
      opcode == OP_SUB:  dec = '{CLS_R, ALU_SUB, 1'b0};
      opcode == OP_AND:  dec = '{CLS_R, ALU_AND, 1'b0};
      opcode == OP_ORR:  dec = '{CLS_R, ALU_OR, 1'b0};
      opcode == OP_LDUR: dec = '{CLS_LOAD, ALU_ADD, 1'b0};
      opcode == OP_STUR: dec = '{CLS_STORE, ALU_ADD, 1'b0};
      opcode[10:2] == OP_MOVZ_HI:
        dec = '{CLS_MOVZ, alu_ctl_e'({2'b10, opcode[1:0]}), 1'b0};
      opcode[10:3] == OP_CBZ_HI:
        dec = '{CLS_BRANCH, ALU_SUB, 1'b0};
`ifdef CBNZ_EN
      opcode[10:3] == OP_CBNZ_HI:
        dec = '{CLS_BRANCH, ALU_SUB, 1'b1};
`endif
      opcode[10:5] == OP_B_HI:
        dec = '{CLS_JUMP, ALU_ADD, 1'b0};
      default: dec = DEC_RST;
    endcase
  end

endmodule

// File: rtl/multicycle_alu_sequencer.sv
// Multicycle LEGv8 control FSM. Ports: clk, reset (sync, active-high), bus (master).
// Param FETCH_TIMEOUT bounds memory waits. Macro CBNZ_EN enables CBNZ decode.
module multicycle_alu_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned FETCH_TIMEOUT = 255
)
(
  input logic                       clk,
  input logic                       reset,
  multicycle_alu_sequencer_if.master bus
);

  localparam logic [7:0] TMO_LAST = 8'(FETCH_TIMEOUT - 1);

  state_e     state_q, state_d;
  decode_t    dec_q, dec_d, dec_w;
  logic [7:0] tmo_q, tmo_d;
  logic       in_mem;

  alu_ctl_e alu_ctl;
  logic     src_a;
  src_b_e   src_b;
  logic     pc_write, pc_write_cond, ir_write;
  logic     mem_read, mem_write, reg_write;
  logic     mem_to_reg, instr_done, fault;

  multicycle_alu_sequencer_opcode_classifier u_cls (
    .opcode (bus.opcode),
    .dec    (dec_w)
  );

  always_comb begin
    state_d = state_q;
    dec_d   = dec_q;
    tmo_d   = tmo_q;
    in_mem  = state_q inside {S_FETCH, S_MEM_RD, S_MEM_WR};
    unique case (state_q)
      S_IDLE:   if (bus.start) state_d = S_FETCH;
      S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        dec_d = dec_w;
        unique case (dec_w.cls)
          CLS_R:      state_d = S_EXEC_R;
          CLS_LOAD:   state_d = S_ADDR;
          CLS_STORE:  state_d = S_ADDR;
          CLS_MOVZ:   state_d = S_EXEC_MOVZ;
          CLS_BRANCH: state_d = S_BRANCH;
          CLS_JUMP:   state_d = S_JUMP;
          default:    state_d = S_FAULT;
        endcase
      end
      S_EXEC_R:    state_d = S_WB_ALU;
      S_EXEC_MOVZ: state_d = S_WB_ALU;
      S_WB_ALU:    state_d = S_FETCH;
      S_ADDR:
        state_d = (dec_q.cls == CLS_LOAD) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: if (bus.mem_ready) state_d = S_WB_MEM;
      S_WB_MEM: state_d = S_FETCH;
      S_MEM_WR: if (bus.mem_ready) state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_FAULT:  state_d = S_FAULT;
      default:  state_d = S_FAULT;
    endcase
    if (in_mem && !bus.mem_ready) begin
      if (tmo_q == TMO_LAST) state_d = S_FAULT;
      else tmo_d = tmo_q + 8'd1;
    end
    if (state_d != state_q) tmo_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      dec_q   <= DEC_RST;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      dec_q   <= dec_d;
      tmo_q   <= tmo_d;
    end
  end

  // Selects follow state only; strobes are qualified by the
  // handshake/flag they complete and are held low during reset.
  always_comb begin
    alu_ctl       = ALU_AND;
    src_a         = 1'b0;
    src_b         = SRC_B_RM;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    instr_done    = 1'b0;
    fault         = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        mem_read = 1'b1;
        src_b    = SRC_B_FOUR;
        alu_ctl  = ALU_ADD;
        ir_write = bus.mem_ready;
        pc_write = bus.mem_ready;
      end
      S_DECODE: begin
        src_b   = SRC_B_IMM_SH2;
        alu_ctl = ALU_ADD;
      end
      S_EXEC_R: begin
        src_a   = 1'b1;
        alu_ctl = dec_q.alu;
      end
      S_EXEC_MOVZ: begin
        src_b   = SRC_B_IMM;
        alu_ctl = dec_q.alu;
      end
      S_WB_ALU: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_ADDR: begin
        src_a   = 1'b1;
        src_b   = SRC_B_IMM;
        alu_ctl = ALU_ADD;
      end
      S_MEM_RD: mem_read = 1'b1;
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_WR: begin
        mem_write  = 1'b1;
        instr_done = bus.mem_ready;
      end
      S_BRANCH: begin
        src_a         = 1'b1;
        alu_ctl       = ALU_SUB;
        pc_write_cond = bus.zero ^ dec_q.neg;
        instr_done    = 1'b1;
      end
      S_JUMP: begin
        pc_write_cond = 1'b1;
        instr_done    = 1'b1;
      end
      S_FAULT: fault = 1'b1;
      default: fault = 1'b0;
    endcase
    if (reset) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      ir_write      = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      reg_write     = 1'b0;
      mem_to_reg    = 1'b0;
      instr_done    = 1'b0;
    end
  end

  assign bus.ALUControl    = alu_ctl;
  assign bus.alu_src_a     = src_a;
  assign bus.alu_src_b     = src_b;
  assign bus.pc_write      = pc_write;
  assign bus.pc_write_cond = pc_write_cond;
  assign bus.ir_write      = ir_write;
  assign bus.mem_read      = mem_read;
  assign bus.mem_write     = mem_write;
  assign bus.reg_write     = reg_write;
  assign bus.mem_to_reg    = mem_to_reg;
  assign bus.instr_done    = instr_done;
  assign bus.fault         = fault;

endmodule

// File: tb/tb_multicycle_alu_sequencer.sv
// Self-checking bench for multicycle_alu_sequencer: per-instruction cycle
// expectations built from the instruction-level behaviour, compared each cycle.
module tb_multicycle_alu_sequencer;

  logic clk;
  logic reset;

  multicycle_alu_sequencer_if bus();

  multicycle_alu_sequencer #(.FETCH_TIMEOUT(255)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // observed vector: {ALUControl, src_a, src_b, 9 strobes}
  localparam logic [8:0] PCW  = 9'h100;
  localparam logic [8:0] PCWC = 9'h080;
  localparam logic [8:0] IRW  = 9'h040;
  localparam logic [8:0] MR   = 9'h020;
  localparam logic [8:0] MW   = 9'h010;
  localparam logic [8:0] RW   = 9'h008;
  localparam logic [8:0] M2R  = 9'h004;
  localparam logic [8:0] DONE = 9'h002;
  localparam logic [8:0] FLT  = 9'h001;
  localparam logic [15:0] M_ALL = 16'hFFFF;
  localparam logic [15:0] M_STB = 16'h01FF;
  localparam logic [15:0] M_RST = 16'h01FE;
  localparam logic [15:0] M_NOA = 16'hF7FF;
  localparam logic [3:0] C_AND = 4'b0000;
  localparam logic [3:0] C_ADD = 4'b0010;
  localparam logic [3:0] C_SUB = 4'b0110;

  localparam logic [10:0] I_ADD  = 11'b10001011000;
  localparam logic [10:0] I_SUB  = 11'b11001011000;
  localparam logic [10:0] I_AND  = 11'b10001010000;
  localparam logic [10:0] I_ORR  = 11'b10101010000;
  localparam logic [10:0] I_LDUR = 11'b11111000010;
  localparam logic [10:0] I_STUR = 11'b11111000000;
  localparam logic [10:0] I_MOVZ = 11'b11010010100;
  localparam logic [10:0] I_CBZ  = 11'b10110100000;
  localparam logic [10:0] I_CBNZ = 11'b10110101000;
  localparam logic [10:0] I_B    = 11'b00010100000;

  localparam int K_R = 0, K_MOVZ = 1, K_LD = 2, K_ST = 3;
  localparam int K_BR = 4, K_J = 5, K_ILL = 6;

  typedef struct {
    logic        rst;
    logic        st;
    logic        rdy;
    logic        z;
    logic [10:0] op;
    logic [15:0] exp;
    logic [15:0] msk;
    string       tag;
  } step_t;

  step_t q[$];
  bit    m_fault;
  string cur;
  int    ncmp = 0;
  int    nerr = 0;

  function automatic logic [15:0] obs();
    return {bus.ALUControl, bus.alu_src_a, bus.alu_src_b,
            bus.pc_write, bus.pc_write_cond, bus.ir_write,
            bus.mem_read, bus.mem_write, bus.reg_write,
            bus.mem_to_reg, bus.instr_done, bus.fault};
  endfunction

  function automatic logic [15:0] ev(input logic [3:0] alu, input logic a,
                                     input logic [1:0] b, input logic [8:0] s);
    return {alu, a, b, s};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic void push(input logic rst, input logic st, input logic rdy,
                               input logic z, input logic [10:0] op,
                               input logic [15:0] e, input logic [15:0] m,
                               input string tag);
    step_t s;
    s.rst = rst; s.st = st; s.rdy = rdy; s.z = z; s.op = op;
    s.exp = e; s.msk = m; s.tag = {cur, ".", tag};
    q.push_back(s);
  endfunction

  // Instruction semantics from the ISA table.
  function automatic void classify(input logic [10:0] op, output int cls,
                                   output logic [3:0] ctl, output logic neg);
    cls = K_ILL; ctl = C_AND; neg = 1'b0;
    if (op == I_ADD) begin cls = K_R; ctl = 4'b0010; end
    else if (op == I_SUB) begin cls = K_R; ctl = 4'b0110; end
    else if (op == I_AND) begin cls = K_R; ctl = 4'b0000; end
    else if (op == I_ORR) begin cls = K_R; ctl = 4'b0001; end
    else if (op == I_LDUR) cls = K_LD;
    else if (op == I_STUR) cls = K_ST;
    else if (op[10:2] == 9'b110100101) begin
      cls = K_MOVZ; ctl = 4'd8 + {2'b00, op[1:0]};
    end
    else if (op[10:3] == 8'b10110100) cls = K_BR;
`ifdef CBNZ_EN
    else if (op[10:3] == 8'b10110101) begin cls = K_BR; neg = 1'b1; end
`endif
    else if (op[10:5] == 6'b000101) cls = K_J;
  endfunction

  function automatic void add_reset();
    push(1'b1, rb(), rb(), rb(), 11'($urandom), 16'h0, M_RST, "rst0");
    push(1'b1, rb(), rb(), rb(), 11'($urandom), 16'h0, M_RST, "rst1");
    push(1'b0, 1'b0, rb(), rb(), 11'($urandom), 16'h0, M_ALL, "idle");
    m_fault = 1'b0;
  endfunction

  function automatic void add_kick();
    push(1'b0, 1'b1, rb(), rb(), 11'($urandom), 16'h0, M_ALL, "start");
  endfunction

  // fd/md: cycles mem_ready stays low in fetch / data access
  function automatic void add_instr(input logic [10:0] op, input logic z,
                                    input int fd, input int md);
    int cls;
    logic [3:0] ctl;
    logic neg;
    if (m_fault) return;
    classify(op, cls, ctl, neg);
    for (int i = 0; i <= fd; i++)
      push(1'b0, rb(), i == fd, rb(), 11'($urandom),
           ev(C_ADD, 1'b0, 2'd1, MR | ((i == fd) ? (PCW | IRW) : 9'h0)),
           M_ALL, "fetch");
    push(1'b0, rb(), rb(), rb(), op, ev(C_ADD, 1'b0, 2'd3, 9'h0), M_ALL, "decode");
    case (cls)
      K_R: begin
        push(1'b0, rb(), rb(), rb(), op, ev(ctl, 1'b1, 2'd0, 9'h0), M_ALL, "exec_r");
        push(1'b0, rb(), rb(), rb(), op, ev(C_AND, 1'b0, 2'd0, RW | DONE), M_STB, "wb_alu");
      end
      K_MOVZ: begin
        push(1'b0, rb(), rb(), rb(), op, ev(ctl, 1'b0, 2'd2, 9'h0), M_NOA, "exec_movz");
        push(1'b0, rb(), rb(), rb(), op, ev(C_AND, 1'b0, 2'd0, RW | DONE), M_STB, "wb_alu");
      end
      K_LD, K_ST: begin
        push(1'b0, rb(), rb(), rb(), op, ev(C_ADD, 1'b1, 2'd2, 9'h0), M_ALL, "addr");
        for (int j = 0; j <= md; j++)
          push(1'b0, rb(), j == md, rb(), op,
               ev(C_AND, 1'b0, 2'd0, (cls == K_LD) ? MR :
                  (MW | ((j == md) ? DONE : 9'h0))),
               M_STB, (cls == K_LD) ? "mem_rd" : "mem_wr");
        if (cls == K_LD)
          push(1'b0, rb(), rb(), rb(), op, ev(C_AND, 1'b0, 2'd0, RW | M2R | DONE),
               M_STB, "wb_mem");
      end
      K_BR:
        push(1'b0, rb(), rb(), z, op,
             ev(C_SUB, 1'b1, 2'd0, (((z == 1'b1) != neg) ? PCWC : 9'h0) | DONE),
             M_ALL, "branch");
      K_J:
        push(1'b0, rb(), rb(), rb(), op, ev(C_AND, 1'b0, 2'd0, PCWC | DONE), M_STB, "jump");
      default: begin
        push(1'b0, rb(), rb(), rb(), op, ev(C_AND, 1'b0, 2'd0, FLT), M_ALL, "fault");
        m_fault = 1'b1;
      end
    endcase
  endfunction

  function automatic logic [10:0] rand_op();
    logic [10:0] lo;
    lo = 11'($urandom);
    case ($urandom_range(0, 8))
      0: return I_ADD;
      1: return I_SUB;
      2: return I_AND;
      3: return I_ORR;
      4: return I_LDUR;
      5: return I_STUR;
      6: return I_MOVZ | {9'b0, lo[1:0]};
      7: return I_CBZ | {8'b0, lo[2:0]};
      default: return I_B | {6'b0, lo[4:0]};
    endcase
  endfunction

  task automatic test_reset();
    logic [15:0] got;
    cur = "reset";
    add_reset();
    push(1'b0, 1'b0, 1'b1, rb(), 11'($urandom), 16'h0, M_ALL, "idle_hold");
    foreach (q[k]) begin
      @(negedge clk);
      reset = q[k].rst; bus.start = q[k].st; bus.mem_ready = q[k].rdy;
      bus.zero = q[k].z; bus.opcode = q[k].op;
      #1;
      got = obs() & q[k].msk;
      ncmp++;
      if (got !== (q[k].exp & q[k].msk)) begin
        nerr++;
        $display("FAIL %s #%0d: got %h expected %h", q[k].tag, k, got, q[k].exp & q[k].msk);
      end
    end
    q.delete();
  endtask

  task automatic test_alu_ops();
    logic [15:0] got;
    cur = "alu";
    add_kick();
    add_instr(I_ADD, 1'b0, 0, 0);
    add_instr(I_MOVZ | 11'b10, 1'b0, 0, 0);
    add_instr(I_SUB, 1'b0, 0, 0);
    add_instr(I_AND, 1'b0, 1, 0);
    add_instr(I_ORR, 1'b0, 0, 0);
    add_instr(I_MOVZ | 11'b11, 1'b0, 2, 0);
    foreach (q[k]) begin
      @(negedge clk);
      reset = q[k].rst; bus.start = q[k].st; bus.mem_ready = q[k].rdy;
      bus.zero = q[k].z; bus.opcode = q[k].op;
      #1;
      got = obs() & q[k].msk;
      ncmp++;
      if (got !== (q[k].exp & q[k].msk)) begin
        nerr++;
        $display("FAIL %s #%0d: got %h expected %h", q[k].tag, k, got, q[k].exp & q[k].msk);
      end
    end
    q.delete();
  endtask

  task automatic test_load_store();
    logic [15:0] got;
    cur = "ldst";
    add_instr(I_LDUR, 1'b0, 0, 3);
    add_instr(I_STUR, 1'b0, 2, 2);
    add_instr(I_LDUR, 1'b0, 0, 0);
    add_instr(I_STUR, 1'b0, 0, 0);
    foreach (q[k]) begin
      @(negedge clk);
      reset = q[k].rst; bus.start = q[k].st; bus.mem_ready = q[k].rdy;
      bus.zero = q[k].z; bus.opcode = q[k].op;
      #1;
      got = obs() & q[k].msk;
      ncmp++;
      if (got !== (q[k].exp & q[k].msk)) begin
        nerr++;
        $display("FAIL %s #%0d: got %h expected %h", q[k].tag, k, got, q[k].exp & q[k].msk);
      end
    end
    q.delete();
  endtask

  task automatic test_branch();
    logic [15:0] got;
    cur = "branch";
    add_instr(I_CBZ | 11'd5, 1'b1, 0, 0);
    add_instr(I_CBZ, 1'b0, 0, 0);
    add_instr(I_B | 11'd17, 1'b0, 0, 0);
    add_instr(I_CBNZ | 11'd2, 1'b0, 0, 0);
    add_instr(I_CBNZ, 1'b1, 0, 0);
    add_reset();
    foreach (q[k]) begin
      @(negedge clk);
      reset = q[k].rst; bus.start = q[k].st; bus.mem_ready = q[k].rdy;
      bus.zero = q[k].z; bus.opcode = q[k].op;
      #1;
      got = obs() & q[k].msk;
      ncmp++;
      if (got !== (q[k].exp & q[k].msk)) begin
        nerr++;
        $display("FAIL %s #%0d: got %h expected %h", q[k].tag, k, got, q[k].exp & q[k].msk);
      end
    end
    q.delete();
  endtask

  task automatic test_random();
    logic [15:0] got;
    cur = "random";
    add_kick();
    for (int n = 0; n < 60; n++)
      add_instr(rand_op(), rb(), $urandom_range(0, 3), $urandom_range(0, 3));
    foreach (q[k]) begin
      @(negedge clk);
      reset = q[k].rst; bus.start = q[k].st; bus.mem_ready = q[k].rdy;
      bus.zero = q[k].z; bus.opcode = q[k].op;
      #1;
      got = obs() & q[k].msk;
      ncmp++;
      if (got !== (q[k].exp & q[k].msk)) begin
        nerr++;
        $display("FAIL %s #%0d: got %h expected %h", q[k].tag, k, got, q[k].exp & q[k].msk);
      end
    end
    q.delete();
  endtask

  task automatic test_illegal();
    logic [15:0] got;
    cur = "illegal";
    add_reset();
    add_kick();
    add_instr(I_ADD, 1'b0, 0, 0);
    add_instr(11'b11111111111, 1'b0, 0, 0);
    for (int n = 0; n < 6; n++)
      push(1'b0, 1'b1, rb(), rb(), 11'($urandom), ev(C_AND, 1'b0, 2'd0, FLT),
           M_ALL, "fault_hold");
    add_reset();
    foreach (q[k]) begin
      @(negedge clk);
      reset = q[k].rst; bus.start = q[k].st; bus.mem_ready = q[k].rdy;
      bus.zero = q[k].z; bus.opcode = q[k].op;
      #1;
      got = obs() & q[k].msk;
      ncmp++;
      if (got !== (q[k].exp & q[k].msk)) begin
        nerr++;
        $display("FAIL %s #%0d: got %h expected %h", q[k].tag, k, got, q[k].exp & q[k].msk);
      end
    end
    q.delete();
  endtask

  task automatic test_timeout();
    logic [15:0] got;
    cur = "timeout";
    add_kick();
    for (int n = 0; n < 255; n++)
      push(1'b0, rb(), 1'b0, rb(), 11'($urandom), ev(C_ADD, 1'b0, 2'd1, MR),
           M_ALL, "fetch_wait");
    push(1'b0, rb(), rb(), rb(), 11'($urandom), ev(C_AND, 1'b0, 2'd0, FLT),
         M_ALL, "fault");
    push(1'b0, 1'b1, 1'b1, rb(), 11'($urandom), ev(C_AND, 1'b0, 2'd0, FLT),
         M_ALL, "fault_hold");
    add_reset();
    foreach (q[k]) begin
      @(negedge clk);
      reset = q[k].rst; bus.start = q[k].st; bus.mem_ready = q[k].rdy;
      bus.zero = q[k].z; bus.opcode = q[k].op;
      #1;
      got = obs() & q[k].msk;
      ncmp++;
      if (got !== (q[k].exp & q[k].msk)) begin
        nerr++;
        $display("FAIL %s #%0d: got %h expected %h", q[k].tag, k, got, q[k].exp & q[k].msk);
      end
    end
    q.delete();
  endtask

  task automatic test_reset_mid_write();
    logic [15:0] got;
    cur = "rst_wr";
    add_kick();
    push(1'b0, 1'b0, 1'b1, 1'b0, 11'($urandom),
         ev(C_ADD, 1'b0, 2'd1, MR | PCW | IRW), M_ALL, "fetch");
    push(1'b0, 1'b0, 1'b0, 1'b0, I_STUR, ev(C_ADD, 1'b0, 2'd3, 9'h0), M_ALL, "decode");
    push(1'b0, 1'b0, 1'b0, 1'b0, I_STUR, ev(C_ADD, 1'b1, 2'd2, 9'h0), M_ALL, "addr");
    push(1'b0, 1'b0, 1'b0, 1'b0, I_STUR, ev(C_AND, 1'b0, 2'd0, MW), M_STB, "mem_wr");
    push(1'b1, 1'b0, 1'b0, 1'b0, I_STUR, 16'h0, M_STB, "rst_cycle");
    push(1'b0, 1'b0, 1'b1, 1'b0, I_STUR, 16'h0, M_ALL, "idle");
    push(1'b0, 1'b0, 1'b1, 1'b0, I_STUR, 16'h0, M_ALL, "idle2");
    add_kick();
    push(1'b0, 1'b0, 1'b0, 1'b0, 11'($urandom), ev(C_ADD, 1'b0, 2'd1, MR),
         M_ALL, "refetch");
    foreach (q[k]) begin
      @(negedge clk);
      reset = q[k].rst; bus.start = q[k].st; bus.mem_ready = q[k].rdy;
      bus.zero = q[k].z; bus.opcode = q[k].op;
      #1;
      got = obs() & q[k].msk;
      ncmp++;
      if (got !== (q[k].exp & q[k].msk)) begin
        nerr++;
        $display("FAIL %s #%0d: got %h expected %h", q[k].tag, k, got, q[k].exp & q[k].msk);
      end
    end
    q.delete();
  endtask

  initial begin
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.mem_ready = 1'b0;
    bus.zero      = 1'b0;
    bus.opcode    = '0;
    m_fault       = 1'b0;
    test_reset();
    test_alu_ops();
    test_load_store();
    test_branch();
    test_random();
    test_illegal();
    test_timeout();
    test_reset_mid_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
